// File: rtl/char_buf_scroll.sv
// Character buffer for the text display path: ROWS x COLS cells in one RAM,
// addressed by logical (row, col), with a hardware scroll offset (top row)
// and a fill engine used for clear-screen and new-line clearing.
module char_buf_scroll #(
    parameter int COLS   = 160,
    parameter int ROWS   = 64,
    parameter int DATA_W = 8,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 6,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r_req,
    input  logic [ROW_W-1:0]  r_row,
    input  logic [COL_W-1:0]  r_col,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid,
    input  logic              w,
    input  logic [ROW_W-1:0]  w_row,
    input  logic [COL_W-1:0]  w_col,
    input  logic [DATA_W-1:0] a_in,
    input  logic              clr,
    input  logic              scroll,
    input  logic [DATA_W-1:0] fill,
    output logic [ROW_W-1:0]  top,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CLEAR, SCROLL_FILL} state_t;

    localparam int               CELLS     = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [COL_W:0]   COLS_EXT  = (COL_W + 1)'(COLS);
    localparam logic [ROW_W:0]   ROWS_EXT  = (ROW_W + 1)'(ROWS);
    localparam logic [COL_W:0]   ONE_LEFT  = (COL_W + 1)'(1);

    // Logical row plus top pointer, wrapped with one conditional subtract
    // (both operands are already below ROWS).
    function automatic logic [ROW_W-1:0] physRow(input logic [ROW_W-1:0] r,
                                                 input logic [ROW_W-1:0] t);
        logic [ROW_W:0] s;
        s = {1'b0, r} + {1'b0, t};
        if (s >= ROWS_EXT) s = s - ROWS_EXT;
        return s[ROW_W-1:0];
    endfunction

    // Row start address as a shift-add of COLS, so no multiplier is needed.
    function automatic logic [ADDR_W-1:0] rowBase(input logic [ROW_W-1:0] r);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ROW_W; i++) begin
            if (r[i]) acc = acc + (ADDR_W'(COLS) << i);
        end
        return acc;
    endfunction

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    top_q, top_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [COL_W:0]      remaining_q, remaining_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic                engWe;

    logic                rdInRange, wrInRange, hostWe, memWe;
    logic [ADDR_W-1:0]   rdAddr, hostAddr, memAddr;
    logic [DATA_W-1:0]   memData;

    logic [DATA_W-1:0]   mem [0:CELLS-1];
    logic [DATA_W-1:0]   rdData_q;
    logic                rdValid_q, rdInRange_q;
    logic [DATA_W-1:0]   a_out_q;
    logic                a_valid_q;

    // Map both logical coordinates to RAM addresses and arbitrate the single
    // write port: the fill engine owns it while busy, host writes are dropped.
    always_comb begin
        rdInRange = ({1'b0, r_col} < COLS_EXT) && ({1'b0, r_row} < ROWS_EXT);
        wrInRange = ({1'b0, w_col} < COLS_EXT) && ({1'b0, w_row} < ROWS_EXT);
        rdAddr    = rowBase(physRow(r_row, top_q)) + ADDR_W'(r_col);
        hostAddr  = rowBase(physRow(w_row, top_q)) + ADDR_W'(w_col);
        hostWe    = w && wrInRange && (state_q == IDLE);
        memWe     = engWe || hostWe;
        memAddr   = engWe ? cnt_q : hostAddr;
        memData   = engWe ? fill_q : a_in;
    end

    // RAM port. The read is taken in the request cycle itself, so a write to
    // the same cell in that cycle is not yet visible (old data is returned).
    always_ff @(posedge clk) begin
        if (memWe) mem[memAddr] <= memData;
        if (r_req && rdInRange) rdData_q <= mem[rdAddr];
    end

    // Read pipeline: request flags after one stage, result after the second;
    // a_out keeps its previous value in cycles without a returning request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdValid_q   <= 1'b0;
            rdInRange_q <= 1'b0;
            a_valid_q   <= 1'b0;
            a_out_q     <= '0;
        end else begin
            rdValid_q   <= r_req;
            rdInRange_q <= r_req && rdInRange;
            a_valid_q   <= rdValid_q;
            if (rdValid_q) a_out_q <= rdInRange_q ? rdData_q : '0;
        end
    end

    // Control state register for the fill engine and the scroll pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            top_q       <= '0;
            cnt_q       <= '0;
            remaining_q <= '0;
            fill_q      <= '0;
        end else begin
            state_q     <= state_d;
            top_q       <= top_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            fill_q      <= fill_d;
        end
    end

    // Command acceptance and fill sequencing. clr beats scroll when both
    // arrive together; commands seen while filling are simply ignored.
    always_comb begin
        state_d     = state_q;
        top_d       = top_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        fill_d      = fill_q;
        engWe       = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    fill_d  = fill;
                    top_d   = '0;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end else if (scroll) begin
                    fill_d      = fill;
                    top_d       = physRow(ROW_W'(1), top_q);
                    cnt_d       = rowBase(top_q);
                    remaining_d = COLS_EXT;
                    state_d     = SCROLL_FILL;
                end
            end
            CLEAR: begin
                engWe = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) state_d = IDLE;
            end
            SCROLL_FILL: begin
                engWe       = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == ONE_LEFT) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign top     = top_q;
    assign busy    = (state_q != IDLE);
    assign a_out   = a_out_q;
    assign a_valid = a_valid_q;

endmodule

// File: tb/tb_char_buf_scroll.sv
// Bench for char_buf_scroll: a 160x64 instance driven by a vector table and
// hand-written sequences, and a 5x3 instance checked every cycle against a
// queue-based model of the buffer.
module tb_char_buf_scroll;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Large instance signals
    logic       bRreq, bW, bClr, bScroll, bValid, bBusy;
    logic [5:0] bRrow, bWrow, bTop;
    logic [7:0] bRcol, bWcol, bIn, bFill, bOut;

    // Small instance signals
    logic       sRreq, sW, sClr, sScroll, sValid, sBusy;
    logic [1:0] sRrow, sWrow, sTop;
    logic [2:0] sRcol, sWcol;
    logic [7:0] sIn, sFill, sOut;

    int checks = 0;
    int errors = 0;

    char_buf_scroll dutBig (
        .clk(clk), .rst(rst),
        .r_req(bRreq), .r_row(bRrow), .r_col(bRcol), .a_out(bOut), .a_valid(bValid),
        .w(bW), .w_row(bWrow), .w_col(bWcol), .a_in(bIn),
        .clr(bClr), .scroll(bScroll), .fill(bFill), .top(bTop), .busy(bBusy)
    );

    char_buf_scroll #(.COLS(5), .ROWS(3), .DATA_W(8), .COL_W(3), .ROW_W(2), .ADDR_W(4)) dutSmall (
        .clk(clk), .rst(rst),
        .r_req(sRreq), .r_row(sRrow), .r_col(sRcol), .a_out(sOut), .a_valid(sValid),
        .w(sW), .w_row(sWrow), .w_col(sWcol), .a_in(sIn),
        .clr(sClr), .scroll(sScroll), .fill(sFill), .top(sTop), .busy(sBusy)
    );

    // Reference model of the small buffer: physical cells, top pointer,
    // pending fill addresses, and the two-deep read result pipe.
    int mMem [15];
    int mTop = 0;
    int mFill = 0;
    int mQ [$];
    logic p1v = 1'b0, p2v = 1'b0;
    int p1d = 0, p2d = 0;
    int lastOut = 0;

    typedef struct {
        logic       isWrite;
        logic [5:0] row;
        logic [7:0] col;
        logic [7:0] data;
    } bigVec_t;

    bigVec_t bigVecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic bWrite(input logic [5:0] row, input logic [7:0] col, input logic [7:0] data);
        bW = 1'b1; bWrow = row; bWcol = col; bIn = data;
        tick();
        bW = 1'b0;
    endtask

    task automatic bRead(input logic [5:0] row, input logic [7:0] col, input logic [7:0] exp,
                         input string name);
        bRreq = 1'b1; bRrow = row; bRcol = col;
        tick();
        bRreq = 1'b0;
        checkOutput({name, "_gap"}, 32'(bValid), 0);
        tick();
        checkOutput({name, "_valid"}, 32'(bValid), 1);
        checkOutput({name, "_data"}, 32'(bOut), 32'(exp));
    endtask

    task automatic bCmd(input logic c, input logic s, input logic [7:0] f);
        bClr = c; bScroll = s; bFill = f;
        tick();
        bClr = 1'b0; bScroll = 1'b0;
    endtask

    task automatic bCountBusy(input string name, input int expCycles);
        int n;
        n = 0;
        while (bBusy === 1'b1 && n < 20000) begin
            n++;
            tick();
        end
        checkOutput(name, n, expCycles);
    endtask

    // One cycle on the small instance: compare outputs with the model, drive
    // the inputs, then advance the model by the same cycle.
    task automatic applyStimulus(input logic req, input int rr, input int rc,
                                 input logic wen, input int wr, input int wc, input int din,
                                 input logic c, input logic s, input int f);
        int nd;
        logic busyNow;
        busyNow = (mQ.size() != 0);
        checkOutput("s_busy", 32'(sBusy), 32'(busyNow));
        checkOutput("s_top", 32'(sTop), mTop);
        checkOutput("s_valid", 32'(sValid), 32'(p2v));
        if (p2v) lastOut = p2d;
        checkOutput("s_out", 32'(sOut), lastOut);

        sRreq = req; sRrow = 2'(rr); sRcol = 3'(rc);
        sW = wen; sWrow = 2'(wr); sWcol = 3'(wc); sIn = 8'(din);
        sClr = c; sScroll = s; sFill = 8'(f);

        nd = (rr < 3 && rc < 5) ? mMem[((rr + mTop) % 3) * 5 + rc] : 0;
        if (busyNow) begin
            mMem[mQ.pop_front()] = mFill;
        end else begin
            if (wen && wr < 3 && wc < 5) mMem[((wr + mTop) % 3) * 5 + wc] = din;
            if (c) begin
                mFill = f;
                mTop = 0;
                for (int i = 0; i < 15; i++) mQ.push_back(i);
            end else if (s) begin
                mFill = f;
                for (int i = 0; i < 5; i++) mQ.push_back(mTop * 5 + i);
                mTop = (mTop + 1) % 3;
            end
        end
        p2v = p1v; p2d = p1d;
        p1v = req; p1d = nd;
        tick();
    endtask

    task automatic sIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic sReadRow(input int row);
        for (int c = 0; c < 5; c++) applyStimulus(1'b1, row, c, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int scrollFill [3];
        int expTop [3];

        rst = 1'b1;
        bRreq = 0; bW = 0; bClr = 0; bScroll = 0; bRrow = 0; bRcol = 0;
        bWrow = 0; bWcol = 0; bIn = 0; bFill = 0;
        sRreq = 0; sW = 0; sClr = 0; sScroll = 0; sRrow = 0; sRcol = 0;
        sWrow = 0; sWcol = 0; sIn = 0; sFill = 0;
        for (int i = 0; i < 15; i++) mMem[i] = 0;

        bigVecs[0] = '{1'b1, 6'd2,  8'd5,   8'h41};
        bigVecs[1] = '{1'b0, 6'd2,  8'd5,   8'h41};
        bigVecs[2] = '{1'b0, 6'd63, 8'd159, 8'h20};
        bigVecs[3] = '{1'b0, 6'd0,  8'd0,   8'h20};
        bigVecs[4] = '{1'b1, 6'd5,  8'd160, 8'h55};
        bigVecs[5] = '{1'b0, 6'd6,  8'd0,   8'h20};
        bigVecs[6] = '{1'b0, 6'd5,  8'd160, 8'h00};
        bigVecs[7] = '{1'b1, 6'd1,  8'd0,   8'h31};
        bigVecs[8] = '{1'b0, 6'd1,  8'd0,   8'h31};
        bigVecs[9] = '{1'b0, 6'd5,  8'd159, 8'h20};

        scrollFill[0] = 'h61; scrollFill[1] = 'h62; scrollFill[2] = 'h63;
        expTop[0] = 1; expTop[1] = 2; expTop[2] = 0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("b_rst_busy", 32'(bBusy), 0);
        checkOutput("b_rst_top", 32'(bTop), 0);
        checkOutput("b_rst_valid", 32'(bValid), 0);
        checkOutput("b_rst_out", 32'(bOut), 0);

        // ---------------- small instance, directed ----------------
        $display("[TB] small buffer directed sequences");
        sIdle(2);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 'h20);
        sIdle(16);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++)
                applyStimulus(1'b0, 0, 0, 1'b1, r, c, 'h40 + r * 5 + c, 1'b0, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1, scrollFill[k]);
            checkOutput("s_top_after_scroll", 32'(sTop), expTop[k]);
            sIdle(5);
            checkOutput("s_scroll_done", 32'(sBusy), 0);
            sReadRow(2);
            sReadRow(0);
            sReadRow(1);
            sIdle(2);
        end
        // out-of-range writes and reads
        applyStimulus(1'b0, 0, 0, 1'b1, 3, 0, 'hEE, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b1, 0, 5, 'hEE, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 3, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 0, 5, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 0, 7, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        sReadRow(0);
        sIdle(2);
        // writes while filling are dropped; reads see partial fill
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 'h71);
        applyStimulus(1'b1, 2, 0, 1'b1, 0, 1, 'hAA, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 2, 1, 1'b1, 2, 2, 'hBB, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 2, 2, 1'b0, 0, 0, 0, 1'b1, 1'b0, 'h99);
        sIdle(3);
        sReadRow(0);
        sReadRow(2);
        sIdle(2);
        // clr and scroll together: clear wins
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 'h30);
        checkOutput("s_clr_wins_top", 32'(sTop), 0);
        sIdle(16);
        sReadRow(1);
        sIdle(2);

        // ---------------- small instance, random ----------------
        $display("[TB] small buffer random traffic");
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 255)), $urandom_range(0, 39) == 0,
                          $urandom_range(0, 9) == 0, int'($urandom_range(0, 255)));
        end
        sIdle(20);

        // ---------------- large instance ----------------
        $display("[TB] large buffer clear");
        bCmd(1'b1, 1'b0, 8'h20);
        checkOutput("b_clr_top", 32'(bTop), 0);
        bCountBusy("b_clr_busy_cycles", 10240);

        $display("[TB] large buffer vector table");
        for (int i = 0; i < 10; i++) begin
            if (bigVecs[i].isWrite)
                bWrite(bigVecs[i].row, bigVecs[i].col, bigVecs[i].data);
            else
                bRead(bigVecs[i].row, bigVecs[i].col, bigVecs[i].data, $sformatf("vec%0d", i));
        end

        $display("[TB] large buffer back-to-back reads");
        bRreq = 1'b1; bRrow = 6'd2; bRcol = 8'd5;
        tick();
        bRrow = 6'd0; bRcol = 8'd0;
        tick();
        bRrow = 6'd2; bRcol = 8'd5;
        checkOutput("b2b_0_valid", 32'(bValid), 1);
        checkOutput("b2b_0_data", 32'(bOut), 'h41);
        tick();
        bRreq = 1'b0;
        checkOutput("b2b_1_valid", 32'(bValid), 1);
        checkOutput("b2b_1_data", 32'(bOut), 'h20);
        tick();
        checkOutput("b2b_2_valid", 32'(bValid), 1);
        checkOutput("b2b_2_data", 32'(bOut), 'h41);
        tick();
        checkOutput("b2b_end_valid", 32'(bValid), 0);
        checkOutput("b2b_hold_data", 32'(bOut), 'h41);

        $display("[TB] large buffer scroll");
        bCmd(1'b0, 1'b1, 8'h2E);
        checkOutput("b_scroll_top", 32'(bTop), 1);
        bCountBusy("b_scroll_busy_cycles", 160);
        bRead(6'd0, 8'd0, 8'h31, "scr_row0");
        bRead(6'd1, 8'd5, 8'h41, "scr_row1");
        bRead(6'd62, 8'd0, 8'h20, "scr_row62");
        for (int c = 0; c < 160; c++)
            bRead(6'd63, 8'(c), 8'h2E, $sformatf("scr_row63_c%0d", c));

        $display("[TB] large buffer write during fill");
        bCmd(1'b0, 1'b1, 8'h2D);
        checkOutput("b_scroll2_top", 32'(bTop), 2);
        bWrite(6'd0, 8'd5, 8'h99);
        bCountBusy("b_scroll2_busy_cycles", 159);
        bRead(6'd0, 8'd5, 8'h41, "busy_write_dropped");
        bRead(6'd63, 8'd7, 8'h2D, "scr2_row63");
        bRead(6'd62, 8'd0, 8'h2E, "scr2_row62");

        $display("[TB] large buffer clr with scroll");
        bCmd(1'b1, 1'b1, 8'h5A);
        checkOutput("b_clr_scroll_top", 32'(bTop), 0);
        bCountBusy("b_clr_scroll_busy_cycles", 10240);
        bRead(6'd2, 8'd5, 8'h5A, "clr2_cell");
        bRead(6'd63, 8'd159, 8'h5A, "clr2_last");

        $display("[TB] large buffer reset during clear");
        bCmd(1'b1, 1'b0, 8'h11);
        repeat (98) tick();
        bRreq = 1'b1; bRrow = 6'd0; bRcol = 8'd0;
        tick();
        bRreq = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("b_midrst_busy", 32'(bBusy), 0);
        checkOutput("b_midrst_top", 32'(bTop), 0);
        checkOutput("b_midrst_valid", 32'(bValid), 0);
        checkOutput("b_midrst_out", 32'(bOut), 0);
        bWrite(6'd3, 8'd3, 8'h77);
        bRead(6'd3, 8'd3, 8'h77, "post_rst_write");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/char_buf_scroll.md
Name: char_buf_scroll

Overview:
- Parametrised character buffer for the text display path.
- Stores ROWS x COLS character cells in one block RAM, addressed by logical (row, col) on both the write and read sides.
- Adds a hardware scroll offset (top-row pointer) and a fill engine, used for clear-screen and new-line clearing.
- Sits between the FSMC host write path and the pixel/character generator read path, in a single clock domain.

Parameters:
COLS, 160, characters per row (any value >= 2; not required to be a power of two)
ROWS, 64, rows (>= 2)
DATA_W, 8, bits per character cell
COL_W, 8, width of column inputs (2^COL_W >= COLS)
ROW_W, 6, width of row inputs (2^ROW_W >= ROWS)
ADDR_W, 14, RAM address width (2^ADDR_W >= COLS*ROWS)

Ports:
clk  in  1  single clock for everything
rst  in  1  synchronous, active-high reset
r_req  in  1  read request
r_row  in  ROW_W  logical read row
r_col  in  COL_W  logical read column
a_out  out  DATA_W  read data
a_valid  out  1  a_out holds the result of a request issued 2 cycles earlier
w  in  1  write strobe
w_row  in  ROW_W  logical write row
w_col  in  COL_W  logical write column
a_in  in  DATA_W  write data
clr  in  1  pulse: fill the whole buffer with `fill`, reset scroll
scroll  in  1  pulse: scroll up one row, fill the new bottom row
fill  in  DATA_W  fill character, latched when clr/scroll is accepted
top  out  ROW_W  current physical row of logical row 0
busy  out  1  fill engine active

Behaviour:
- Mapping: phys_row = (row + top) mod ROWS; addr = phys_row*COLS + col.
  - No multiplier on the datapath: use an ADDR_W-wide shift-add or a registered accumulate.
  - Modulo is a single conditional subtract, since row < ROWS and top < ROWS.
- Read pipeline, fixed latency 2.
  - Cycle N: sample r_req/r_row/r_col and top.
  - N+1: registered address plus in-range flag.
  - N+2: a_out and a_valid=1.
  - Fully pipelined: one request per cycle. a_valid=0 in cycles with no request N-2; a_out holds its last value.
  - Out of range (r_row>=ROWS or r_col>=COLS): a_out=0 with a_valid=1.
- Read/write collision: a read of the same cell written in the same cycle returns the old data.
- Direct write: w=1 with in-range row/col and busy=0 writes a_in at the mapped address in the same cycle.
  - Out-of-range writes are dropped.
  - Writes while busy=1 are dropped; the host must poll busy.
- FSM states: IDLE, CLEAR, SCROLL_FILL.
  - IDLE + clr: latch fill, top<=0, cnt<=0, go to CLEAR. clr wins over scroll if both are asserted together.
  - IDLE + scroll (no clr): latch fill; top<=(top+1) mod ROWS; cnt<=old_top*COLS; remaining<=COLS; go to SCROLL_FILL.
  - CLEAR: write fill at cnt, cnt++ each cycle. After writing address COLS*ROWS-1, go to IDLE.
  - SCROLL_FILL: write fill at cnt, cnt++, remaining--. After COLS writes, go to IDLE.
  - clr/scroll pulses outside IDLE are ignored (not queued).
- busy timing:
  - Command accepted at cycle N: busy=1 from N+1. Engine writes occur in cycles N+1 .. N+K (K = ROWS*COLS for clr, COLS for scroll). busy=0 at N+K+1.
  - top updates at N+1.
- Reads during busy are allowed and return the current RAM contents, which may be partially filled.
- Reset (any state, including mid-fill):
  - state IDLE, top=0, busy=0, a_valid=0, a_out=0, read pipeline flushed.
  - RAM contents are not initialised; software issues clr after reset.
- Wrap-around: scroll with top=ROWS-1 sets top=0 and fills physical row ROWS-1.

Test Plan:
- COLS=160, ROWS=64: rst, clr with fill=0x20 at cycle 10 -> busy high cycles 11..10250, low at 10251; read (63,159) then returns 0x20 with a_valid 2 cycles after request.
- Write (row 2, col 5)=0x41, then r_req (2,5) -> a_out=0x41 exactly 2 cycles later; back-to-back reads of (2,5),(0,0),(2,5) -> 0x41,0x20,0x41 on consecutive cycles.
- Write (1,0)=0x31; scroll fill=0x2E -> top=1, busy exactly 160 cycles. Then read (0,0) -> 0x31 and read (63,0..159) -> 0x2E.
- COLS=5, ROWS=3: three scrolls -> top 1,2,0; after each scroll the logical bottom row reads fill; the physical row filled equals the old top.
- w during busy and r_row=64 or r_col=160 -> write dropped, RAM unchanged; out-of-range read -> 0x00 with a_valid=1. clr and scroll asserted in the same cycle -> CLEAR only, top=0.
- rst asserted mid-CLEAR at engine cycle 100 -> next cycle busy=0, top=0, a_valid=0; a following w succeeds immediately.
